// File: rtl/exc_pkg.sv
// Shared types and constants for the external interrupt path of the
// single-cycle core with exceptions.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_state_t;

  // EStatus cause codes, also used by the main decoder.
  localparam logic [3:0] ESTAT_EXTIRQ   = 4'b0001;
  localparam logic [3:0] ESTAT_NOTINSTR = 4'b0010;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req_i (index 0
// wins) and whether any bit is set at all.
module irq_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    idx_o
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Multi-source external interrupt controller: edge-latched pending bits,
// fixed-priority arbitration and a non-nesting REQ/SERVICE handshake.
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               ExtIAck,
  input  logic               ERet,
  input  logic [NUM_SRC-1:0] ovr_clr,
  output logic               ExtIRQ,
  output logic [ID_W-1:0]    irq_id,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun
);

  irq_state_t         state_q;
  logic               ext_irq_q;
  logic [ID_W-1:0]    irq_id_q;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;

  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] ack_clr;
  logic               ack_take;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;

  assign edge_det = irq_src & ~src_q;
  assign ack_take = (state_q == REQ) && ExtIAck;
  assign ack_clr  = ack_take ? (NUM_SRC'(1) << irq_id_q) : '0;

  // Masked pending bits stay latched; only arbitration honours irq_en.
  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req_i   (pending_q & irq_en),
    .valid_o (win_valid),
    .idx_o   (win_id)
  );

  // A new edge beats a same-cycle clear for both pending and overrun.
  always_comb begin
    pending_d = (pending_q & ~ack_clr) | edge_det;
    overrun_d = (overrun_q & ~ovr_clr) | (edge_det & pending_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      src_q     <= irq_src;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ext_irq_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            irq_id_q  <= win_id;
            ext_irq_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (ExtIAck) begin
            ext_irq_q <= 1'b0;
            state_q   <= SERVICE;
          end
        end
        SERVICE: begin
          if (ERet) state_q <= IDLE;
        end
        default: begin
          ext_irq_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ExtIRQ  = ext_irq_q;
  assign irq_id  = irq_id_q;
  assign busy    = (state_q != IDLE);
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule
